// File: rtl/logic_unit_pipe.sv
//------------------------------------------------------------------------------
// Module   : logic_unit_pipe
// Brief    : Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready
//            handshakes, last-result chaining and registered zero/parity flags.
//            Optional macro LOGIC_POPCNT_EN adds a registered popcnt output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_prev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
`ifdef LOGIC_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  localparam logic [2:0] C_OP_AND  = 3'b000;
  localparam logic [2:0] C_OP_OR   = 3'b001;
  localparam logic [2:0] C_OP_XOR  = 3'b010;
  localparam logic [2:0] C_OP_NOTA = 3'b011;
  localparam logic [2:0] C_OP_NAND = 3'b100;
  localparam logic [2:0] C_OP_NOR  = 3'b101;
  localparam logic [2:0] C_OP_XNOR = 3'b110;

  logic [WIDTH-1:0] r_res1;
  logic             r_v1;
  logic [WIDTH-1:0] r_lr;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;
  logic             r_out_valid;

  logic             w_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_res;

  assign w_adv      = !r_out_valid || out_ready;
  assign w_in_ready = !r_v1 || w_adv;
  assign w_accept   = in_valid && w_in_ready;
  // Chaining reads lr directly, so a use_prev beat right behind its producer sees it.
  assign w_opa      = use_prev ? r_lr : a;

  always_comb begin
    w_res = b;
    case (op)
      C_OP_AND:  w_res = w_opa & b;
      C_OP_OR:   w_res = w_opa | b;
      C_OP_XOR:  w_res = w_opa ^ b;
      C_OP_NOTA: w_res = ~w_opa;
      C_OP_NAND: w_res = ~(w_opa & b);
      C_OP_NOR:  w_res = ~(w_opa | b);
      C_OP_XNOR: w_res = ~(w_opa ^ b);
      default:   w_res = b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res1      <= '0;
      r_v1        <= 1'b0;
      r_lr        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_parity    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_adv) begin
        if (r_v1) begin
          r_result    <= r_res1;
          r_zero      <= ~|r_res1;
          r_parity    <= ^r_res1;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_accept) begin
        r_res1 <= w_res;
        r_v1   <= 1'b1;
        r_lr   <= w_res;
      end else if (w_adv) begin
        r_v1   <= 1'b0;
      end
    end
  end

`ifdef LOGIC_POPCNT_EN
  localparam int POPW = $clog2(WIDTH+1);

  logic [POPW-1:0] w_pop;
  logic [POPW-1:0] r_popcnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + POPW'(r_res1[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_popcnt <= '0;
    end else if (w_adv && r_v1) begin
      r_popcnt <= w_pop;
    end
  end

  assign popcnt = r_popcnt;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign parity    = r_parity;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_logic_unit_pipe
// Brief    : Scoreboard bench for logic_unit_pipe (honours LOGIC_POPCNT_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_logic_unit_pipe;

  localparam int W    = 8;
  localparam int POPW = $clog2(W+1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         use_prev = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         parity;
`ifdef LOGIC_POPCNT_EN
  logic [POPW-1:0] popcnt;
`endif

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_prev  (use_prev),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity)
`ifdef LOGIC_POPCNT_EN
    ,
    .popcnt    (popcnt)
`endif
  );

  always #5 clk = ~clk;

  int           vectors = 0;
  int           errors  = 0;
  int           cyc     = 0;
  int           last_acc_cyc = 0;
  logic [W-1:0] exp_q[$];
  int           pop_cyc[$];
  logic [W-1:0] m_lr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model_f(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~x;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output beat is popped and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        check("result", result, e);
        check("zero", zero, (e == '0));
        check("parity", parity, $countones(e) % 2);
`ifdef LOGIC_POPCNT_EN
        check("popcnt", popcnt, $countones(e));
`endif
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic iv, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic up, input bit has_exp,
                       input logic [W-1:0] ex, output bit acc);
    logic [W-1:0] r;
    in_valid = iv; op = o; a = x; b = y; use_prev = up;
    @(negedge clk);
    acc = iv && in_ready;
    if (acc) begin
      r = model_f(o, up ? m_lr : x, y);
      m_lr = r;
      exp_q.push_back(has_exp ? ex : r);
      last_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic up, input bit has_exp, input logic [W-1:0] ex);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, o, x, y, up, has_exp, ex, acc);
      if (acc) return;
    end
    check("send_timeout", 1, 0);
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      cycle(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0, acc);
    cycle(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0, acc);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] b2b[8];
    bit acc;
    int n;
    b2b = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'hFA, 8'h50, 8'h55, 8'h0F};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_parity", parity, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single beat and latency.
    out_ready = 1'b1;
    send(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h30);
    n = pop_cyc.size();
    drain();
    check("latency", pop_cyc[n] - last_acc_cyc, 2);

    // Eight opcodes back to back, results must stream with no gaps.
    n = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F, 1'b0, 1'b1, b2b[i]);
    drain();
    check("b2b_count", pop_cyc.size() - n, 8);
    check("b2b_no_gap", pop_cyc[n+7] - pop_cyc[n], 7);

    // Chaining through the last-result register.
    send(3'd7, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hFF);
    send(3'd2, 8'h00, 8'h0F, 1'b1, 1'b1, 8'hF0);
    send(3'd0, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h30);
    drain();

    // Backpressure: only two beats fit while the output is stalled.
    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 3'd2, 8'(8'h11 * (n + 1)), 8'h81, 1'b0, 1'b0, '0, acc);
      if (acc) n++;
    end
    check("bp_accepted", n, 2);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    send(3'd2, 8'h33, 8'h81, 1'b0, 1'b1, 8'hB2);
    send(3'd2, 8'h44, 8'h81, 1'b0, 1'b1, 8'hC5);
    drain();

    // NOT of all ones gives zero.
    send(3'd3, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
    send(3'd7, 8'h00, 8'h7F, 1'b0, 1'b1, 8'h7F);
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(3'd1, 8'h5A, 8'h01, 1'b0, 1'b1, 8'h5B);
    send(3'd1, 8'hA0, 8'h01, 1'b0, 1'b1, 8'hA1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    exp_q.delete();
    m_lr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00);
    drain();

    // Random traffic against the model with random backpressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(($urandom_range(0, 9) < 7), 3'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 1'b0, '0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit. Successor to the fixed 4-bit AND/OR/XOR and 8-bit NOT gate arrays.
- Single WIDTH-bit datapath with a 3-bit opcode and valid/ready handshakes on input and output.
- Result chaining through an internal last-result register.
- Registered zero/parity flags.
- Sits between the operand-issue logic and the result bus of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
op  input  3  opcode, sampled with operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
use_prev  input  1  1 = replace A with last-result register
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result beat
result  output  WIDTH  logic result
zero  output  1  result == 0
parity  output  1  XOR-reduction of result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: in_ready=1 (derived), out_valid=0, result=0, zero=0, parity=0. Stage-1 valid=0. Last-result register (lr)=0.
- Opcodes: 000 A&B, 001 A|B, 010 A^B, 011 ~A, 100 ~(A&B), 101 ~(A|B), 110 ~(A^B), 111 B (pass).
- Effective A = use_prev ? lr : a.
- Accept: a beat is accepted when in_valid && in_ready.
- Stage 1, on accept: res1 <= f(op, effective A, b); v1 <= 1; lr <= same computed value.
- Stage 2: when adv = !out_valid || out_ready and v1=1, result <= res1, zero <= ~|res1, parity <= ^res1, out_valid <= 1. The stage-1 entry is consumed.
- If adv=1 and v1=0, out_valid <= 0.
- Stage 1 loads only on accept. Otherwise v1 clears when consumed by stage 2.
- Latency: 2 cycles from accept to out_valid, with no stall.
- Throughput: 1 beat/cycle.
- in_ready = !v1 || adv (combinational from out_ready).
- Backpressure: with out_ready=0 and both stages full, in_ready=0 and all registers hold. Nothing is dropped or duplicated.
- Chaining: lr updates at accept time, so back-to-back use_prev beats see the immediately preceding result. No bubble is needed.
- use_prev with op 111 ignores A: result=b, and lr still updates.
- Simultaneous: in the same cycle, stage 2 takes the old res1 and stage 1 loads the new beat.
- in_valid with in_ready=0: inputs are ignored and lr is unchanged.
- Reset mid-operation: all in-flight beats are discarded immediately. out_valid drops asynchronously and lr returns to 0.
- All operations are pure bitwise at WIDTH bits. No carries, no width extension.

Optional Feature:
LOGIC_POPCNT_EN:
- Defined: adds output port popcnt, width $clog2(WIDTH+1), holding the number of 1 bits in result.
- popcnt is registered in stage 2 alongside zero/parity, has the same timing, and resets to 0.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Reset, then op=000 a=8'hF0 b=8'h3C, one beat, out_ready=1 -> two cycles later out_valid=1, result=8'h30, zero=0, parity=0.
- Eight back-to-back beats a=8'hA5 b=8'h0F, op 000..111 -> results 05, AF, AA, 5A, FA, 50, 55, 0F on consecutive cycles with no gaps.
- Chain: beat1 op=111 b=8'hFF; beat2 op=010 use_prev=1 b=8'h0F; beat3 op=000 use_prev=1 b=8'h3C -> FF, F0, 30. Parity 0, 0, 0; zero 0 throughout.
- Backpressure: hold out_ready=0 while sending 4 beats -> in_ready drops after 2 accepted. Release -> remaining beats emerge in order, none lost or duplicated.
- op=011 a=8'hFF -> result=00, zero=1, parity=0. With LOGIC_POPCNT_EN, result=8'h7F gives popcnt=7.
- Assert rst_n=0 with both stages full -> out_valid=0 immediately. After release, use_prev=1 op=001 b=8'h00 -> result=00 (lr cleared).
